iter_divider: RTL and testbench
===============================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (>= 4).
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request pulse; operands sampled on the same edge.
REQ-005 Port: dividend  input  WIDTH  signed two's-complement dividend.
REQ-006 Port: divisor  input  WIDTH  signed two's-complement divisor.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: result_rdy  output  1  one-cycle pulse marking quotient/exception valid.
REQ-009 Port: quotient  output  WIDTH  signed quotient, held until the next accepted start.
REQ-010 Port: exception  output  1  divide-by-zero or overflow flag, valid with result_rdy, held with quotient.

Function
REQ-011 States SHALL be IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-012 start SHALL be accepted only in IDLE or DONE; start in CALC/FIX SHALL be ignored with no effect.
REQ-013 On accept with divisor != 0: latch |dividend|, |divisor|, result sign (sign XOR), clear partial remainder, load counter = WIDTH, go CALC; busy=1 next cycle.
REQ-014 CALC, one quotient bit per cycle, MSB first: shift remainder left taking next dividend bit; trial subtract divisor; if non-negative keep difference and set bit, else restore; decrement counter.
REQ-015 When counter reaches 0 SHALL go FIX; FIX applies two's-complement negation to quotient (and remainder per REQ-024) when required, then DONE.
REQ-016 DONE SHALL assert result_rdy for exactly one cycle and drop busy in the same cycle; next cycle IDLE unless a new start is accepted.
REQ-017 Latency: start sampled at edge 0 -> result_rdy high during cycle WIDTH+2 (34 for WIDTH=32).
REQ-018 Divisor == 0: skip CALC/FIX, go DONE directly; quotient=0, exception=1; result_rdy during cycle 1.
REQ-019 Dividend == most-negative and divisor == -1: quotient = most-negative value, exception=1, normal latency.
REQ-020 Division SHALL truncate toward zero; remainder sign follows dividend.
REQ-021 exception SHALL be 0 for all other operand pairs.
REQ-022 Trial subtraction SHALL be WIDTH+1 bits to avoid loss of the shifted-out MSB.

Reset
REQ-023 resetn low SHALL, without waiting for clock, force IDLE, busy=0, result_rdy=0, quotient=0, exception=0, counter=0; an operation in flight is discarded and never signals result_rdy.

Configuration
REQ-024 Macro ITER_DIVIDER_REMAINDER_EN defined: extra output port remainder (WIDTH, signed), valid and held like quotient, 0 on reset and on divide-by-zero; undefined: port absent, remainder register still internal, no other behaviour change.

Structure
REQ-025 Shared package div_pkg SHALL hold the state encoding constants (IDLE, CALC, FIX, DONE) and the default WIDTH constant.
REQ-026 Trial subtraction SHALL be a sub-module cla_subtractor (WIDTH+1 bits, lookahead carry, A - B via B inverted and carry-in 1, outputs difference and borrow).

Verification
REQ-027 dividend=7, divisor=2, start pulse -> result_rdy at cycle 34, quotient=3, exception=0, remainder=1 (macro on).
REQ-028 dividend=-7, divisor=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1, exception=0.
REQ-029 dividend=100, divisor=0 -> result_rdy at cycle 1, quotient=0, exception=1, busy never high.
REQ-030 dividend=0x80000000, divisor=-1 -> quotient=0x80000000, exception=1 at cycle 34.
REQ-031 start 1000/10, second start 9/3 at cycle 5 -> second ignored; quotient=100 at cycle 34; no second result_rdy.
REQ-032 start 50/5, resetn low at cycle 10 for 1 cycle -> outputs cleared immediately, no result_rdy; new start 50/5 after release -> quotient=10 after 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM state encoding
// and the default operand width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/cla_subtractor.sv
// N-bit subtractor a - b built as a + ~b + 1 with a parallel-prefix
// (Kogge-Stone) carry lookahead network. borrow is high when a < b.
module cla_subtractor #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    localparam int L = $clog2(N);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] gc;   // group generate from bit 0 (with carry-in) up to bit i

    assign p = a ^ ~b;
    assign g = a & ~b;

    // Prefix tree: the constant carry-in of 1 is folded into bit 0's generate.
    always_comb begin
        logic [N-1:0] gv, pv, gn, pn;
        gv    = g;
        gv[0] = g[0] | p[0];
        pv    = p;
        for (int s = 0; s < L; s++) begin
            gn = gv;
            pn = pv;
            for (int i = 0; i < N; i++) begin
                if (i >= (1 << s)) begin
                    gn[i] = gv[i] | (pv[i] & gv[i - (1 << s)]);
                    pn[i] = pv[i] & pv[i - (1 << s)];
                end
            end
            gv = gn;
            pv = pn;
        end
        gc = gv;
    end

    assign diff   = p ^ {gc[N-2:0], 1'b1};
    assign borrow = ~gc[N-1];

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring signed divider, one quotient bit per clock, MSB first.
// Magnitudes are divided, then the FIX state restores the signs (quotient
// truncated toward zero, remainder takes the dividend's sign).
// Optional: define ITER_DIVIDER_REMAINDER_EN to expose the remainder port.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] quotient,
`ifdef ITER_DIVIDER_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             exception
);
    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;     // holds |dividend| and shifts quotient bits in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;     // |divisor|
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             exc_q, exc_d;
    logic             accept;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             unused_diff_msb;

    // Shifted partial remainder is one bit wider than the operands so the
    // bit shifted out of rem_q is not lost before the compare.
    assign trial_a = {rem_q, quo_q[WIDTH-1]};

    cla_subtractor #(.N(WIDTH + 1)) u_sub (
        .a      (trial_a),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Remainder after a successful subtract is always below the divisor.
    assign unused_diff_msb = trial_diff[WIDTH];

    // Next-state and datapath update; a fresh start overrides IDLE/DONE.
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        exc_d   = exc_q;
        accept  = start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            CALC: begin
                if (trial_borrow) begin
                    rem_d = trial_a[WIDTH-1:0];
                end else begin
                    rem_d = trial_diff[WIDTH-1:0];
                end
                quo_d   = {quo_q[WIDTH-2:0], ~trial_borrow};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_d == '0) ? FIX : CALC;
            end
            FIX: begin
                if (qneg_q) quo_d = ~quo_q + 1'b1;
                if (rneg_q) rem_d = ~rem_q + 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            rem_d = '0;
            if (divisor == '0) begin
                quo_d   = '0;
                dvs_d   = '0;
                cnt_d   = '0;
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
                exc_d   = 1'b1;
                state_d = DONE;
            end else begin
                quo_d   = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
                dvs_d   = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
                cnt_d   = CNT_INIT;
                qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                rneg_d  = dividend[WIDTH-1];
                // MOST_NEG / -1 falls out of the magnitude path unchanged; only flag it.
                exc_d   = (dividend == MOST_NEG) && (divisor == '1);
                state_d = CALC;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            exc_q  <= exc_d;
        end
    end

    assign busy       = (state_q == CALC) || (state_q == FIX);
    assign result_rdy = (state_q == DONE);
    assign quotient   = quo_q;
    assign exception  = exc_q;
`ifdef ITER_DIVIDER_REMAINDER_EN
    assign remainder  = rem_q;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider (WIDTH=32).
module tb_iter_divider;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, result_rdy, exception;
    logic [W-1:0] quotient;
`ifdef ITER_DIVIDER_REMAINDER_EN
    logic [W-1:0] remainder;
`endif

    iter_divider #(.WIDTH(W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .result_rdy (result_rdy),
        .quotient   (quotient),
`ifdef ITER_DIVIDER_REMAINDER_EN
        .remainder  (remainder),
`endif
        .exception  (exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         exc;
        int           lat;
        int           st;
        logic         zdiv;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   busy_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.st   = 0;
        e.zdiv = 1'b0;
        e.lat  = W + 2;
        if (b == '0) begin
            e.q = '0; e.r = '0; e.exc = 1'b1; e.lat = 1; e.zdiv = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = '0; e.exc = 1'b1;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: every result_rdy must match the oldest expected result.
    always @(negedge clock) begin : mon
        exp_t e;
        if (busy) busy_seen = 1'b1;
        if (result_rdy) begin
            if (sb.size() == 0) begin
                chk("spurious_rdy", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("exception", exception, e.exc);
                chk("latency", 64'(cyc - e.st + 1), 64'(e.lat));
                chk("busy_at_rdy", busy, 1'b0);
`ifdef ITER_DIVIDER_REMAINDER_EN
                chk("remainder", remainder, e.r);
`endif
                if (e.zdiv) chk("busy_div0", busy_seen, 1'b0);
            end
        end
    end

    // Present one start pulse; optionally register the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (push) begin
            e = model(a, b);
            e.st = cyc;
            busy_seen = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        issue(a, b, 1'b1);
        drain();
        repeat (2) @(negedge clock);
        chk("q_held", quotient, e.q);
        chk("exc_held", exception, e.exc);
    endtask

    initial begin : wdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        logic [W-1:0] ra, rb;
        int k;

        // Reset state
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", result_rdy, 1'b0);
        chk("rst_q", quotient, '0);
        chk("rst_exc", exception, 1'b0);
`ifdef ITER_DIVIDER_REMAINDER_EN
        chk("rst_rem", remainder, '0);
`endif
        @(negedge clock);
        resetn = 1'b1;

        // Directed operand patterns and boundaries
        run_op(32'd7, 32'd2);
        run_op(-32'sd7, 32'd2);
        run_op(32'd100, 32'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF);
        run_op(-32'sd100, -32'sd7);
        run_op(32'd7, -32'sd2);
        run_op(32'd0, 32'd5);
        run_op(32'd5, 32'd7);
        run_op(32'h7FFF_FFFF, 32'd1);
        run_op(32'h8000_0000, 32'd1);
        run_op(32'h8000_0000, 32'h7FFF_FFFF);

        // Random operands of varying magnitude
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == '0) rb = 32'd3;
            run_op(ra, rb);
        end

        // Start while busy must be ignored
        issue(32'd1000, 32'd10, 1'b1);
        repeat (3) @(negedge clock);
        issue(32'd9, 32'd3, 1'b0);
        chk("busy_mid", busy, 1'b1);
        drain();
        repeat (10) @(negedge clock);
        chk("ignored_q", quotient, 32'd100);

        // New start accepted in the DONE cycle
        issue(32'd21, 32'd4, 1'b1);
        k = 0;
        while (!result_rdy && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("b2b_rdy_seen", result_rdy, 1'b1);
        dividend = -32'sd45;
        divisor  = 32'd6;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        e = model(-32'sd45, 32'd6);
        e.st = cyc;
        busy_seen = 1'b0;
        sb.push_back(e);
        chk("b2b_busy", busy, 1'b1);
        drain();
        repeat (2) @(negedge clock);

        // Asynchronous reset mid-operation
        issue(32'd50, 32'd5, 1'b0);
        repeat (8) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdy", result_rdy, 1'b0);
        chk("arst_q", quotient, '0);
        chk("arst_exc", exception, 1'b0);
`ifdef ITER_DIVIDER_REMAINDER_EN
        chk("arst_rem", remainder, '0);
`endif
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        chk("arst_idle", busy, 1'b0);
        run_op(32'd50, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
